uart_tx_ctrl: RTL

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 92 +++++++++
 1 files changed

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: serializes a parallel word as start / LSB-first data / optional parity / stop.
// tx_out and busy are registered from the next-state decode so they change with the state they describe.
module uart_tx_ctrl #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [DATA_WIDTH-1:0] p_data,
   input  logic                  data_valid,
   input  logic                  par_en,
   input  logic                  par_bit,
   output logic                  tx_out,
   output logic                  busy
);
   // state  | meaning
   // IDLE   | line held high, waiting for data_valid
   // START  | start bit (0), one cycle
   // DATA   | latched word bit[cnt], LSB first, DATA_WIDTH cycles
   // PARITY | latched parity bit, one cycle, only when par_en was latched high
   // STOP   | stop bit (1), one cycle; a new request here chains straight into START

   localparam int CNT_W = $clog2(DATA_WIDTH) + 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [CNT_W-1:0]      cnt;
   logic [CNT_W-1:0]      cnt_nxt;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  par_en_q;
   logic                  par_bit_q;
   logic                  accept;
   logic                  last_bit;
   logic                  tx_nxt;
   logic                  busy_nxt;

   assign accept   = data_valid && ((state == IDLE) || (state == STOP));
   assign last_bit = (cnt == CNT_W'(DATA_WIDTH - 1));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state     <= IDLE;
         cnt       <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_bit_q <= 1'b0;
         tx_out    <= 1'b1;
         busy      <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         tx_out <= tx_nxt;
         busy   <= busy_nxt;
         if (accept) begin
            data_q    <= p_data;
            par_en_q  <= par_en;
            par_bit_q <= par_bit;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = START;
         START:   state_nxt = DATA;
         DATA:    if (last_bit) state_nxt = par_en_q ? PARITY : STOP;
         PARITY:  state_nxt = STOP;
         STOP:    state_nxt = accept ? START : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Output values are those of the state being entered, so the register lands in step with it.
   always_comb begin
      cnt_nxt  = '0;
      tx_nxt   = 1'b1;
      busy_nxt = 1'b1;
      if ((state == DATA) && (state_nxt == DATA)) begin
         cnt_nxt = cnt + CNT_W'(1);
      end
      case (state_nxt)
         IDLE:    busy_nxt = 1'b0;
         START:   tx_nxt   = 1'b0;
         DATA:    tx_nxt   = |(data_q & (DATA_WIDTH'(1) << cnt_nxt));
         PARITY:  tx_nxt   = par_bit_q;
         default: tx_nxt   = 1'b1;
      endcase
   end

endmodule
